// File: rtl/jtcontra_gfx_objdma.sv
// -----------------------------------------------------------------------------
// jtcontra_gfx_objdma
//
// Object-table DMA and scan buffer for the 007121 object path. On the falling
// edge of LVBL (start of vertical blank) the 64-sprite attribute table
// (320 bytes) is copied out of object RAM into a private buffer. The object
// scanner reads that buffer during active video, so CPU writes to object RAM
// never tear a frame that is being drawn.
//
// Ports:
//   rst        async active-high reset
//   clk        system clock, rising edge
//   LVBL       vertical blank, active low; its falling edge starts a copy,
//              its rising edge aborts a copy in progress
//   obj_page   object RAM half select, latched at copy start
//   dma_addr   object RAM read address (registered)
//   dma_din    object RAM data, one clk after dma_addr
//   dma_busy   high while a copy is in progress
//   dma_done   one-clk pulse on the final cycle of a completed copy
//   scan_addr  scanner read address
//   obj_scan   scanner read data, one clk latency; 240 beyond the table
//
// Configuration:
//   JTCONTRA_OBJ_DBUF_EN  defined   -> two banks, swapped on copy completion
//                         undefined -> one bank, written live during a copy
// -----------------------------------------------------------------------------
module jtcontra_gfx_objdma (
  input  logic        rst,
  input  logic        clk,
  input  logic        LVBL,
  input  logic        obj_page,
  output logic [10:0] dma_addr,
  input  logic [7:0]  dma_din,
  output logic        dma_busy,
  output logic        dma_done,
  input  logic [9:0]  scan_addr,
  output logic [7:0]  obj_scan
);

  localparam int unsigned TABLE_LEN = 320;
  localparam logic [8:0]  LAST_CNT  = 9'd319;
  localparam logic [7:0]  Y_TERM    = 8'd240;

  typedef enum logic [1:0] {
    IDLE,
    COPY,
    FLUSH
  } state_t;

  state_t      state_q,     state_d;
  logic [8:0]  cnt_q,       cnt_d;
  logic        page_q,      page_d;
  logic        last_lvbl_q, last_lvbl_d;
  logic [10:0] dma_addr_q,  dma_addr_d;
  logic [7:0]  obj_scan_q,  obj_scan_d;

  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        done;
  logic [8:0]  scan_idx;
  logic [7:0]  rd_byte;

`ifdef JTCONTRA_OBJ_DBUF_EN
  logic        front_q, front_d;
  logic [7:0]  bank0 [TABLE_LEN];
  logic [7:0]  bank1 [TABLE_LEN];
`else
  logic [7:0]  bank0 [TABLE_LEN];
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    page_d      = page_q;
    dma_addr_d  = dma_addr_q;
    last_lvbl_d = LVBL;
    wr_en       = 1'b0;
    // RAM data lags the address by one clk, so the byte arriving now belongs
    // to the previous count.
    wr_addr     = cnt_q - 9'd1;
    wr_data     = dma_din;
    done        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (last_lvbl_q && !LVBL) begin
          state_d    = COPY;
          cnt_d      = 9'd0;
          page_d     = obj_page;
          dma_addr_d = {obj_page, 10'd0};
        end
      end

      COPY: begin
        if (LVBL) begin
          state_d = IDLE;
        end else begin
          wr_en = (cnt_q != 9'd0);
          // cnt keeps running to 320 so FLUSH writes byte 319 via cnt-1.
          cnt_d = cnt_q + 9'd1;
          if (cnt_q == LAST_CNT) begin
            state_d = FLUSH;
          end else begin
            // base + cnt: base only has bit 10 set and cnt < 512.
            dma_addr_d = {page_q, 1'b0, cnt_d};
          end
        end
      end

      FLUSH: begin
        state_d = IDLE;
        if (!LVBL) begin
          wr_en = 1'b1;
          done  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef JTCONTRA_OBJ_DBUF_EN
  assign front_d = front_q ^ done;
`endif

  // ---------------------------------------------------------------------------
  // Scanner read path
  // ---------------------------------------------------------------------------
  assign scan_idx = scan_addr[8:0];

  always_comb begin
`ifdef JTCONTRA_OBJ_DBUF_EN
    rd_byte = front_q ? bank1[scan_idx] : bank0[scan_idx];
`else
    rd_byte = bank0[scan_idx];
`endif
    // Out-of-table addresses read as a y=240 terminator to end the list.
    obj_scan_d = (scan_addr < 10'(TABLE_LEN)) ? rd_byte : Y_TERM;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 9'd0;
      page_q      <= 1'b0;
      last_lvbl_q <= 1'b1;
      dma_addr_q  <= 11'd0;
      obj_scan_q  <= 8'd0;
`ifdef JTCONTRA_OBJ_DBUF_EN
      front_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      page_q      <= page_d;
      last_lvbl_q <= last_lvbl_d;
      dma_addr_q  <= dma_addr_d;
      obj_scan_q  <= obj_scan_d;
`ifdef JTCONTRA_OBJ_DBUF_EN
      front_q     <= front_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Table storage
  // ---------------------------------------------------------------------------
  // NOTE: the banks have no reset; contents are fully rewritten by each copy
  // and a reset term would prevent mapping onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
`ifdef JTCONTRA_OBJ_DBUF_EN
      // The back bank is the one not being scanned.
      if (front_q) bank0[wr_addr] <= wr_data;
      else         bank1[wr_addr] <= wr_data;
`else
      bank0[wr_addr] <= wr_data;
`endif
    end
  end

  assign dma_addr = dma_addr_q;
  assign dma_busy = (state_q != IDLE);
  assign dma_done = done;
  assign obj_scan = obj_scan_q;

endmodule

// File: tb/tb_jtcontra_gfx_objdma.sv
// -----------------------------------------------------------------------------
// tb_jtcontra_gfx_objdma
//
// Directed bench for jtcontra_gfx_objdma. An object RAM model returns
// (page1 ? ~addr[7:0] : addr[7:0]) ^ key one clk after the address. Copies are
// started by dropping LVBL; busy length, done timing, addresses and scanner
// reads are compared against hand-computed values. Inputs are driven and
// outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_jtcontra_gfx_objdma;

  logic        rst;
  logic        clk;
  logic        LVBL;
  logic        obj_page;
  logic [10:0] dma_addr;
  logic [7:0]  dma_din;
  logic        dma_busy;
  logic        dma_done;
  logic [9:0]  scan_addr;
  logic [7:0]  obj_scan;

  int          total = 0;
  int          bad   = 0;

  logic [7:0]  key;
  int          busy_cycles;
  int          done_at;
  int          done_cnt;
  logic [10:0] addr_first;
  logic [10:0] addr_last;
  logic [7:0]  scan_hist [0:330];

  jtcontra_gfx_objdma dut (
    .rst       (rst),
    .clk       (clk),
    .LVBL      (LVBL),
    .obj_page  (obj_page),
    .dma_addr  (dma_addr),
    .dma_din   (dma_din),
    .dma_busy  (dma_busy),
    .dma_done  (dma_done),
    .scan_addr (scan_addr),
    .obj_scan  (obj_scan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Object RAM model: registered read, one clk latency.
  always @(posedge clk) begin
    dma_din <= (dma_addr[10] ? ~dma_addr[7:0] : dma_addr[7:0]) ^ key;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic read_check(input logic [9:0] a, input logic [7:0] exp,
                            input string tag);
    scan_addr = a;
    @(negedge clk);
    check(tag, {24'd0, obj_scan}, {24'd0, exp});
  endtask

  // Drops LVBL and watches 330 cycles; k counts cycles after the sampling
  // edge T. scan_addr is held at 5 to record the scanner view of byte 5.
  task automatic run_copy(input logic page, input int abort_at,
                          input int flip_at);
    obj_page  = page;
    scan_addr = 10'd5;
    LVBL      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    LVBL        = 1'b0;
    busy_cycles = 0;
    done_at     = -1;
    done_cnt    = 0;
    addr_first  = '1;
    addr_last   = '1;
    for (int k = 1; k <= 330; k++) begin
      @(negedge clk);
      scan_hist[k] = obj_scan;
      if (dma_busy) busy_cycles++;
      if (dma_done) begin
        done_cnt++;
        done_at = k;
      end
      if (k == 1)   addr_first = dma_addr;
      if (k == 320) addr_last  = dma_addr;
      if (k == flip_at)  obj_page = ~obj_page;
      if (k == abort_at) LVBL = 1'b1;
    end
    LVBL = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    LVBL      = 1'b1;
    obj_page  = 1'b0;
    scan_addr = 10'd0;
    key       = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_busy",  {31'd0, dma_busy}, 32'd0);
    check("rst_done",  {31'd0, dma_done}, 32'd0);
    check("rst_addr",  {21'd0, dma_addr}, 32'd0);
    check("rst_scan",  {24'd0, obj_scan}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Copy 1: page 0, byte = addr[7:0]. LVBL stays low after completion,
    // so the busy count also proves no restart without a fresh edge.
    run_copy(1'b0, 0, 0);
    check("c1_busy_len",   busy_cycles, 32'd321);
    check("c1_done_at",    done_at,     32'd321);
    check("c1_done_cnt",   done_cnt,    32'd1);
    check("c1_addr_first", {21'd0, addr_first}, 32'h000);
    check("c1_addr_last",  {21'd0, addr_last},  32'h13F);
    read_check(10'h00A, 8'h0A, "c1_rd_00a");
    read_check(10'h13F, 8'h3F, "c1_rd_13f");
    read_check(10'h0FF, 8'hFF, "c1_rd_0ff");
    read_check(10'h100, 8'h00, "c1_rd_100");
    read_check(10'h140, 8'd240, "term_140");
    read_check(10'h200, 8'd240, "term_200");
    read_check(10'h3FF, 8'd240, "term_3ff");

    // Copy 2: page 1 (byte = ~addr[7:0]); page flips to 0 mid-copy and
    // must have no effect.
    run_copy(1'b1, 0, 100);
    check("c2_busy_len",   busy_cycles, 32'd321);
    check("c2_done_at",    done_at,     32'd321);
    check("c2_addr_first", {21'd0, addr_first}, 32'h400);
    check("c2_addr_last",  {21'd0, addr_last},  32'h53F);
    read_check(10'h000, 8'hFF, "c2_rd_000");
    read_check(10'h005, 8'hFA, "c2_rd_005");
    read_check(10'h13F, 8'hC0, "c2_rd_13f");

    // Copy 3: page 0 with key 0x55; byte 5 goes 0xFA -> 0x50.
    key = 8'h55;
    run_copy(1'b0, 0, 0);
    check("c3_done_cnt", done_cnt, 32'd1);
`ifdef JTCONTRA_OBJ_DBUF_EN
    check("c3_scan_k9",   {24'd0, scan_hist[9]},   32'hFA);
    check("c3_scan_k322", {24'd0, scan_hist[322]}, 32'hFA);
    check("c3_scan_k323", {24'd0, scan_hist[323]}, 32'h50);
`else
    check("c3_scan_k8",   {24'd0, scan_hist[8]},   32'hFA);
    check("c3_scan_k9",   {24'd0, scan_hist[9]},   32'h50);
    check("c3_scan_k323", {24'd0, scan_hist[323]}, 32'h50);
`endif
    read_check(10'h13F, 8'h6A, "c3_rd_13f");

    // Copy 4: key 0xA0, LVBL rises at T+100. Bytes 0..97 are written before
    // the abort in the single-bank build.
    key = 8'hA0;
    run_copy(1'b0, 100, 0);
    check("ab_busy_len", busy_cycles, 32'd100);
    check("ab_done_cnt", done_cnt,    32'd0);
`ifdef JTCONTRA_OBJ_DBUF_EN
    read_check(10'd5,   8'h50, "ab_rd_5");
    read_check(10'd97,  8'h34, "ab_rd_97");
`else
    read_check(10'd5,   8'hA5, "ab_rd_5");
    read_check(10'd97,  8'hC1, "ab_rd_97");
`endif
    read_check(10'd98,  8'h37, "ab_rd_98");
    read_check(10'd200, 8'h9D, "ab_rd_200");

    // Async reset mid-copy, asserted between clock edges.
    key       = 8'h0F;
    obj_page  = 1'b1;
    @(negedge clk);
    LVBL = 1'b0;
    repeat (50) @(negedge clk);
    check("ar_busy_pre", {31'd0, dma_busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("ar_busy", {31'd0, dma_busy}, 32'd0);
    check("ar_addr", {21'd0, dma_addr}, 32'd0);
    check("ar_scan", {24'd0, obj_scan}, 32'd0);
    LVBL = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_copy(1'b1, 0, 0);
    check("ar_busy_len", busy_cycles, 32'd321);
    check("ar_done_at",  done_at,     32'd321);
    check("ar_done_cnt", done_cnt,    32'd1);
    read_check(10'h000, 8'hF0, "ar_rd_000");
    read_check(10'h13F, 8'hCF, "ar_rd_13f");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtcontra_gfx_objdma.md
# jtcontra_gfx_objdma

Object-table DMA and scan buffer for the 007121 object path. At the start of vertical blank it copies the 64-sprite attribute table (320 bytes, 5 bytes/sprite) out of object RAM into a private buffer. During active video it serves the object scanner's `scan_addr`/`obj_scan` reads from that buffer, so CPU writes to object RAM never tear a frame in progress. It sits directly upstream of the object line-drawing stage.

## Interface
- No parameters.
- `rst`  in  1  asynchronous, active-high reset
- `clk`  in  1  system clock; all logic on rising edge
- `LVBL`  in  1  vertical blank, active low; falling edge starts a copy
- `obj_page`  in  1  source half select; sampled at copy start; source base = `{obj_page, 10'd0}`
- `dma_addr`  out  11  object RAM read address
- `dma_din`  in  8  object RAM data, valid exactly one clk after `dma_addr`
- `dma_busy`  out  1  high while copying
- `dma_done`  out  1  one-clk pulse when a copy completes
- `scan_addr`  in  10  scanner read address
- `obj_scan`  out  8  scanner read data, registered, one-clk latency

## Operation
- Edge detect: `last_LVBL` is registered. The condition `last_LVBL & ~LVBL` in IDLE starts a copy.
- States:
  - IDLE → COPY on the start condition.
  - COPY issues reads with `cnt` = 0..319 and `dma_addr = base + cnt`. Each write to the back buffer uses the previous cycle's `cnt`, so the write address is `cnt-1`, with `dma_din` as data.
  - After `cnt` = 319 is issued, state goes to FLUSH for one cycle, which writes byte 319.
  - FLUSH → IDLE with `dma_done`=1 for that cycle and a buffer swap.
- Buffer: two banks of 320×8. `front` serves `scan_addr` and `back` = `~front` receives writes. `front` toggles on the cycle `dma_done` is asserted.
- Read path: if `scan_addr` < 320, `obj_scan` = `front[scan_addr]`; otherwise `obj_scan` = 8'd240 (y=240 terminator, so the scanner ends the list).
- Abort: if `LVBL` rises during COPY or FLUSH, return to IDLE immediately. In that case there is no swap, no `dma_done`, and the front buffer is untouched.
- A new falling edge on `LVBL` while busy is ignored; no restart.
- `obj_page` is latched into `base` at the start of COPY. Changes to it mid-copy have no effect.
- Reset mid-copy: everything goes to reset values and `front`=0. Buffer contents are not cleared.
- Reset values:
  - `dma_addr`=0, `dma_busy`=0, `dma_done`=0, `obj_scan`=0
  - state IDLE, `cnt`=0, `front`=0, `last_LVBL`=1

## Timing
- Cycle T: `LVBL` falling edge sampled. At T+1, state is COPY, `dma_busy`=1 and `dma_addr`=base.
- `dma_addr` = base+319 at T+320. FLUSH at T+321 writes byte 319 and asserts `dma_done`. The swap takes effect at T+322, and `dma_busy`=0 from T+322.
- Total copy is 321 clk, well inside a vblank line period.
- Scanner read latency is 1 clk: `scan_addr` presented in cycle N gives `obj_scan` valid in cycle N+1.
- A scanner read in the same cycle as the swap returns the old front bank. The read on the next cycle uses the new bank.

## Configuration
- `JTCONTRA_OBJ_DBUF_EN` defined: two banks with swap as described.
- Undefined: a single 320-byte bank, with no `front` register. COPY writes the live bank directly and `dma_done` still pulses.
  - Abort leaves a partially updated table.
  - Scanner reads during a copy return whatever is currently stored.

## Test plan
- Reset: object RAM model fills page 0 with byte = `addr[7:0]`. Drop `LVBL`. Expect:
  - `dma_busy` high for 321 clk and `dma_done` at T+321.
  - Then `scan_addr`=0x0A → `obj_scan`=0x0A, and `scan_addr`=0x13F → 0x3F.
- With `obj_page`=1 and RAM byte = `~addr[7:0]`: after copy, `scan_addr`=0 → 0xFF. Toggling `obj_page` mid-copy changes nothing.
- Double buffer (`JTCONTRA_OBJ_DBUF_EN`): after copy A, start copy B with different data. During B, `scan_addr`=5 still returns A's value; one clk after B's `dma_done` it returns B's value.
- Abort: raise `LVBL` at T+100. Expect:
  - `dma_busy` falls the next clk, no `dma_done`.
  - With `JTCONTRA_OBJ_DBUF_EN`, reads still return the previous frame for every address.
- Terminator and ignore: `scan_addr`=0x140 and 0x3FF → 8'd240. A second `LVBL` falling edge while busy does not restart; `dma_done` occurs exactly once.
- Async reset asserted at T+50 with no clock edge: `dma_busy`=0 and `dma_addr`=0 immediately. After release, a new `LVBL` edge runs a full 321-clk copy.
